// File: rtl/wb_forward_rf_if.sv
// rtl/wb_forward_rf_if.sv - writeback pipeline and forwarding register file signal bundle
interface wb_forward_rf_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ex_wd_i;
    logic              ex_wreg_i;
    logic [DATA_W-1:0] ex_wdata_i;
    logic              stall_i;
    logic              flush_i;
    logic              re1_i;
    logic              re2_i;
    logic [ADDR_W-1:0] raddr1_i;
    logic [ADDR_W-1:0] raddr2_i;
    logic [DATA_W-1:0] rdata1_o;
    logic [DATA_W-1:0] rdata2_o;
    logic [1:0]        fwd1_o;
    logic [1:0]        fwd2_o;
    logic [ADDR_W-1:0] mem_wd_o;
    logic              mem_wreg_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [ADDR_W-1:0] wb_wd_o;
    logic              wb_wreg_o;
    logic [DATA_W-1:0] wb_wdata_o;

    modport master (
        output ex_wd_i, ex_wreg_i, ex_wdata_i, stall_i, flush_i,
        output re1_i, re2_i, raddr1_i, raddr2_i,
        input  rdata1_o, rdata2_o, fwd1_o, fwd2_o,
        input  mem_wd_o, mem_wreg_o, mem_wdata_o,
        input  wb_wd_o, wb_wreg_o, wb_wdata_o
    );

    modport slave (
        input  ex_wd_i, ex_wreg_i, ex_wdata_i, stall_i, flush_i,
        input  re1_i, re2_i, raddr1_i, raddr2_i,
        output rdata1_o, rdata2_o, fwd1_o, fwd2_o,
        output mem_wd_o, mem_wreg_o, mem_wdata_o,
        output wb_wd_o, wb_wreg_o, wb_wdata_o
    );
endinterface

// File: rtl/wb_forward_rf.sv
// rtl/wb_forward_rf.sv - EX/MEM and MEM/WB pipeline registers with a forwarding register file
module wb_forward_rf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    wb_forward_rf_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [ADDR_W-1:0] mem_wd_q, mem_wd_d, wb_wd_q, wb_wd_d;
    logic              mem_wreg_q, mem_wreg_d, wb_wreg_q, wb_wreg_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, wb_wdata_q, wb_wdata_d;
    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DATA_W-1:0] rf_d [DEPTH];

    logic              re_v [2];
    logic [ADDR_W-1:0] ra_v [2];
    logic [DATA_W-1:0] rd_v [2];
    logic [1:0]        fw_v [2];

    // A stall holds EX/MEM and pushes a bubble into MEM/WB; flush clears both.
    always_comb begin
        mem_wd_d    = mem_wd_q;
        mem_wreg_d  = mem_wreg_q;
        mem_wdata_d = mem_wdata_q;
        wb_wd_d     = '0;
        wb_wreg_d   = 1'b0;
        wb_wdata_d  = '0;
        if (bus.flush_i) begin
            mem_wd_d    = '0;
            mem_wreg_d  = 1'b0;
            mem_wdata_d = '0;
        end else if (!bus.stall_i) begin
            mem_wd_d    = bus.ex_wd_i;
            mem_wreg_d  = bus.ex_wreg_i;
            mem_wdata_d = bus.ex_wdata_i;
            wb_wd_d     = mem_wd_q;
            wb_wreg_d   = mem_wreg_q;
            wb_wdata_d  = mem_wdata_q;
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_wreg_q && wb_wd_q != '0) begin
            rf_d[wb_wd_q] = wb_wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wd_q    <= '0;
            mem_wreg_q  <= 1'b0;
            mem_wdata_q <= '0;
            wb_wd_q     <= '0;
            wb_wreg_q   <= 1'b0;
            wb_wdata_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            mem_wd_q    <= mem_wd_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_wdata_q <= mem_wdata_d;
            wb_wd_q     <= wb_wd_d;
            wb_wreg_q   <= wb_wreg_d;
            wb_wdata_q  <= wb_wdata_d;
            rf_q        <= rf_d;
        end
    end

    // Youngest producer wins; a zero address never matches because raddr 0 is filtered first.
    always_comb begin
        re_v[0] = bus.re1_i;
        re_v[1] = bus.re2_i;
        ra_v[0] = bus.raddr1_i;
        ra_v[1] = bus.raddr2_i;
        for (int p = 0; p < 2; p++) begin
            rd_v[p] = '0;
            fw_v[p] = 2'd0;
            if (rst && re_v[p] && ra_v[p] != '0) begin
                if (bus.ex_wreg_i && bus.ex_wd_i == ra_v[p]) begin
                    rd_v[p] = bus.ex_wdata_i;
                    fw_v[p] = 2'd1;
                end else if (mem_wreg_q && mem_wd_q == ra_v[p]) begin
                    rd_v[p] = mem_wdata_q;
                    fw_v[p] = 2'd2;
                end else if (wb_wreg_q && wb_wd_q == ra_v[p]) begin
                    rd_v[p] = wb_wdata_q;
                    fw_v[p] = 2'd3;
                end else begin
                    rd_v[p] = rf_q[ra_v[p]];
                end
            end
        end
    end

    assign bus.rdata1_o    = rd_v[0];
    assign bus.rdata2_o    = rd_v[1];
    assign bus.fwd1_o      = fw_v[0];
    assign bus.fwd2_o      = fw_v[1];
    assign bus.mem_wd_o    = mem_wd_q;
    assign bus.mem_wreg_o  = mem_wreg_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.wb_wd_o     = wb_wd_q;
    assign bus.wb_wreg_o   = wb_wreg_q;
    assign bus.wb_wdata_o  = wb_wdata_q;
endmodule

// File: tb/tb_wb_forward_rf.sv
// tb/tb_wb_forward_rf.sv - scoreboard bench for wb_forward_rf
module tb_wb_forward_rf;
    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } wr_t;

    typedef struct {
        logic [31:0] rd1;
        logic [1:0]  f1;
        logic [31:0] rd2;
        logic [1:0]  f2;
        wr_t         mem;
        wr_t         wb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] regs [32];
    wr_t         st_mem, st_wb;
    exp_t        exp_q [$];

    always #5 clk = ~clk;

    wb_forward_rf_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    wb_forward_rf #(.DATA_W(32), .ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Operand lookup: scan producers youngest first, fall back to the stored value.
    function automatic void model_read(input logic re, input logic [4:0] a, input wr_t ex,
                                       output logic [31:0] d, output logic [1:0] f);
        wr_t stages [3];
        stages[0] = ex;
        stages[1] = st_mem;
        stages[2] = st_wb;
        d = 32'd0;
        f = 2'd0;
        if (!re || a == 5'd0) return;
        for (int i = 0; i < 3; i++) begin
            if (stages[i].wreg && stages[i].wd == a) begin
                d = stages[i].wdata;
                f = 2'(i + 1);
                return;
            end
        end
        d = regs[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        st_mem = '0;
        st_wb  = '0;
    endtask

    task automatic cycle(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input logic stall, input logic flush,
                         input logic re1, input logic [4:0] ra1,
                         input logic re2, input logic [4:0] ra2);
        exp_t e;
        wr_t  ex;
        @(negedge clk);
        bus.ex_wd_i = wd;  bus.ex_wreg_i = wreg; bus.ex_wdata_i = wdata;
        bus.stall_i = stall; bus.flush_i = flush;
        bus.re1_i = re1; bus.raddr1_i = ra1; bus.re2_i = re2; bus.raddr2_i = ra2;
        ex = '{wd: wd, wreg: wreg, wdata: wdata};
        model_read(re1, ra1, ex, e.rd1, e.f1);
        model_read(re2, ra2, ex, e.rd2, e.f2);
        e.mem = st_mem;
        e.wb  = st_wb;
        exp_q.push_back(e);
        @(posedge clk);
        if (st_wb.wreg && st_wb.wd != 5'd0) regs[st_wb.wd] = st_wb.wdata;
        if (flush) begin
            st_mem = '0;
            st_wb  = '0;
        end else if (stall) begin
            st_wb = '0;
        end else begin
            st_wb  = st_mem;
            st_mem = ex;
        end
    endtask

    task automatic idle(input logic [4:0] ra1, input logic [4:0] ra2);
        cycle(5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, ra1, 1'b1, ra2);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rdata1", 64'(bus.rdata1_o), 64'(e.rd1));
                check("fwd1", 64'(bus.fwd1_o), 64'(e.f1));
                check("rdata2", 64'(bus.rdata2_o), 64'(e.rd2));
                check("fwd2", 64'(bus.fwd2_o), 64'(e.f2));
                check("mem_stage", 64'({bus.mem_wd_o, bus.mem_wreg_o, bus.mem_wdata_o}), 64'(e.mem));
                check("wb_stage", 64'({bus.wb_wd_o, bus.wb_wreg_o, bus.wb_wdata_o}), 64'(e.wb));
            end
        end
    end

    initial begin : stimulus
        model_clear();
        bus.ex_wd_i = 5'd3; bus.ex_wreg_i = 1'b1; bus.ex_wdata_i = 32'h1234_5678;
        bus.stall_i = 1'b0; bus.flush_i = 1'b0;
        bus.re1_i = 1'b1; bus.raddr1_i = 5'd3; bus.re2_i = 1'b1; bus.raddr2_i = 5'd3;
        #2;
        check("rst_rdata1", 64'(bus.rdata1_o), 64'd0);
        check("rst_fwd1", 64'(bus.fwd1_o), 64'd0);
        check("rst_mem_wreg", 64'(bus.mem_wreg_o), 64'd0);
        check("rst_wb_wreg", 64'(bus.wb_wreg_o), 64'd0);
        @(negedge clk);
        bus.ex_wd_i = 5'd0; bus.ex_wreg_i = 1'b0; bus.ex_wdata_i = 32'd0;
        rst = 1'b1;

        // EX -> MEM -> WB -> array for one result
        cycle(5'd3, 1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0);
        repeat (3) cycle(5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0);
        // writes to r0 are dropped
        cycle(5'd0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0);
        repeat (3) idle(5'd0, 5'd0);
        // youngest producer wins
        cycle(5'd5, 1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5);
        cycle(5'd5, 1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5);
        repeat (3) idle(5'd5, 5'd5);
        // stall keeps EX/MEM forwarding alive
        cycle(5'd7, 1'b1, 32'h5, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 5'd7);
        repeat (2) cycle(5'd0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0);
        repeat (3) idle(5'd7, 5'd7);
        // flush wins over stall
        cycle(5'd9, 1'b1, 32'h99, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        repeat (3) idle(5'd9, 5'd9);
        cycle(5'd9, 1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 5'd9, 1'b1, 5'd9);
        cycle(5'd0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 5'd9);
        repeat (3) idle(5'd9, 5'd9);

        // asynchronous reset with reg4 sitting in MEM/WB
        cycle(5'd4, 1'b1, 32'h7, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1, 5'd4);
        idle(5'd4, 5'd4);
        #3;
        rst = 1'b0;
        bus.ex_wd_i = 5'd4; bus.ex_wreg_i = 1'b1; bus.ex_wdata_i = 32'hDEAD;
        #1;
        check("arst_rdata1", 64'(bus.rdata1_o), 64'd0);
        check("arst_fwd1", 64'(bus.fwd1_o), 64'd0);
        check("arst_rdata2", 64'(bus.rdata2_o), 64'd0);
        check("arst_fwd2", 64'(bus.fwd2_o), 64'd0);
        check("arst_wb_wreg", 64'(bus.wb_wreg_o), 64'd0);
        check("arst_mem_wreg", 64'(bus.mem_wreg_o), 64'd0);
        bus.ex_wd_i = 5'd0; bus.ex_wreg_i = 1'b0; bus.ex_wdata_i = 32'd0;
        rst = 1'b1;
        model_clear();
        repeat (3) idle(5'd4, 5'd9);

        for (int n = 0; n < 600; n++) begin
            cycle(5'($urandom_range(0, 9)), 1'($urandom_range(0, 3) != 0), $urandom(),
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 11) == 0),
                  1'($urandom_range(0, 9) != 0), 5'($urandom_range(0, 9)),
                  1'($urandom_range(0, 9) != 0), 5'($urandom_range(0, 9)));
        end
        repeat (2) idle(5'd1, 5'd2);

        repeat (2) @(negedge clk);
        #5;
        check("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
